// File: rtl/fft8_frame_ctrl.sv
// fft8_frame_ctrl: gathers 8 ADC samples into a frame, launches it onto the combinational
// 8-point FFT core, captures the 16 result words after a settle delay and streams bins 0..7
// out under valid/ready.
// Optional feature: define FFT8_MAG_EN to add m_mag = sat(|re| + |im|) per bin.
module fft8_frame_ctrl #(
    parameter int unsigned DW         = 32,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_data,
    output logic [8*DW-1:0] fft_x,
    input  logic [8*DW-1:0] fft_re,
    input  logic [8*DW-1:0] fft_im,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [2:0]      m_bin,
    output logic [DW-1:0]   m_re,
    output logic [DW-1:0]   m_im,
    output logic            m_last,
    output logic            busy,
`ifdef FFT8_MAG_EN
    output logic [DW-1:0]   m_mag,
`endif
    output logic [15:0]     frame_cnt
);

    typedef enum logic [1:0] {StFill, StSettle, StCapture, StDrain} state_e;

    state_e               state_q, state_d;
    logic [2:0]           wr_idx_q;
    logic [2:0]           rd_idx_q;
    logic [3:0]           settle_q;
    logic [6:0][DW-1:0]   slot_q;   // slot 7 goes straight from s_data to fft_x at launch
    logic [7:0][DW-1:0]   cap_re_q;
    logic [7:0][DW-1:0]   cap_im_q;
    logic                 s_fire;
    logic                 m_fire;

    assign s_fire = (state_q == StFill) && s_valid;
    assign m_fire = (state_q == StDrain) && m_ready;

`ifdef FFT8_MAG_EN
    localparam logic [DW-1:0] MaxPos = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MinNeg = {1'b1, {(DW-1){1'b0}}};

    logic [7:0][DW-1:0] cap_mag_q;
    logic [7:0][DW-1:0] mag_calc;

    // Absolute value; the most-negative code has no positive twin, so it clips.
    function automatic logic [DW-1:0] abs_sat(input logic [DW-1:0] v);
        if (v == MinNeg) return MaxPos;
        else if (v[DW-1]) return -v;
        else return v;
    endfunction

    // Per-bin L1 magnitude, clipped to the largest positive value.
    always_comb begin
        logic [DW:0] sum;
        mag_calc = '0;
        for (int k = 0; k < 8; k++) begin
            sum = {1'b0, abs_sat(fft_re[k*DW +: DW])} + {1'b0, abs_sat(fft_im[k*DW +: DW])};
            mag_calc[k] = (sum > {1'b0, MaxPos}) ? MaxPos : sum[DW-1:0];
        end
    end

    // Magnitudes are captured together with the results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cap_mag_q <= '0;
        else if (state_q == StCapture) cap_mag_q <= mag_calc;
    end

    assign m_mag = (state_q == StDrain) ? cap_mag_q[rd_idx_q] : '0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StFill;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill:    if (s_fire && wr_idx_q == 3'd7) state_d = StSettle;
            StSettle:  if (settle_q == 4'd1) state_d = StCapture;
            StCapture: state_d = StDrain;
            StDrain:   if (m_fire && rd_idx_q == 3'd7) state_d = StFill;
            default:   state_d = StFill;
        endcase
    end

    // Frame assembly, settle timing, capture and drain bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            settle_q  <= '0;
            slot_q    <= '0;
            fft_x     <= '0;
            cap_re_q  <= '0;
            cap_im_q  <= '0;
            frame_cnt <= '0;
        end else begin
            unique case (state_q)
                StFill: begin
                    if (s_fire) begin
                        if (wr_idx_q == 3'd7) begin
                            fft_x    <= {s_data, slot_q};
                            wr_idx_q <= '0;
                            settle_q <= 4'(SETTLE_CYC);
                        end else begin
                            slot_q[wr_idx_q] <= s_data;
                            wr_idx_q         <= wr_idx_q + 3'd1;
                        end
                    end
                end
                StSettle: settle_q <= settle_q - 4'd1;
                StCapture: begin
                    cap_re_q <= fft_re;
                    cap_im_q <= fft_im;
                    rd_idx_q <= '0;
                end
                StDrain: begin
                    if (m_fire) begin
                        rd_idx_q <= rd_idx_q + 3'd1;
                        if (rd_idx_q == 3'd7) frame_cnt <= frame_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and result outputs; result fields read zero outside DRAIN.
    always_comb begin
        s_ready = (state_q == StFill);
        busy    = (state_q != StFill);
        m_valid = (state_q == StDrain);
        m_bin   = m_valid ? rd_idx_q : 3'd0;
        m_re    = m_valid ? cap_re_q[rd_idx_q] : '0;
        m_im    = m_valid ? cap_im_q[rd_idx_q] : '0;
        m_last  = m_valid && (rd_idx_q == 3'd7);
    end

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// tb_fft8_frame_ctrl: drives directed and random frames into fft8_frame_ctrl, stands in for
// the FFT core with a rounded floating-point DFT of fft_x, and checks every streamed bin
// against a DFT of the samples the bench sent.
module tb_fft8_frame_ctrl;

    localparam int DW     = 32;
    localparam int SETTLE = 3;
    localparam real PI    = 3.14159265358979323846;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [DW-1:0]   s_data = '0;
    logic [8*DW-1:0] fft_x;
    logic [8*DW-1:0] fft_re;
    logic [8*DW-1:0] fft_im;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [2:0]      m_bin;
    logic [DW-1:0]   m_re;
    logic [DW-1:0]   m_im;
    logic            m_last;
    logic            busy;
    logic [15:0]     frame_cnt;
`ifdef FFT8_MAG_EN
    logic [DW-1:0]   m_mag;
`endif

    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_frame[8];
    int          last_x[8];
    logic [15:0] exp_cnt = '0;

    fft8_frame_ctrl #(.DW(DW), .SETTLE_CYC(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .fft_x     (fft_x),
        .fft_re    (fft_re),
        .fft_im    (fft_im),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_bin     (m_bin),
        .m_re      (m_re),
        .m_im      (m_im),
        .m_last    (m_last),
        .busy      (busy),
`ifdef FFT8_MAG_EN
        .m_mag     (m_mag),
`endif
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // X[k] of the 8 packed samples, rounded to nearest integer.
    function automatic int dft(input logic [8*DW-1:0] v, input int k, input bit imag);
        real acc;
        real ang;
        acc = 0.0;
        for (int n = 0; n < 8; n++) begin
            ang = 2.0 * PI * real'(k * n) / 8.0;
            if (imag) acc = acc - real'($signed(v[n*DW +: DW])) * $sin(ang);
            else      acc = acc + real'($signed(v[n*DW +: DW])) * $cos(ang);
        end
        return (acc >= 0.0) ? $rtoi(acc + 0.5) : -$rtoi(0.5 - acc);
    endfunction

    function automatic logic [8*DW-1:0] pack(input int f[8]);
        logic [8*DW-1:0] v;
        for (int n = 0; n < 8; n++) v[n*DW +: DW] = f[n];
        return v;
    endfunction

    // Stand-in for the combinational FFT core.
    always_comb begin
        fft_re = '0;
        fft_im = '0;
        for (int k = 0; k < 8; k++) begin
            fft_re[k*DW +: DW] = dft(fft_x, k, 1'b0);
            fft_im[k*DW +: DW] = dft(fft_x, k, 1'b1);
        end
    end

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        else n_pass++;
    endtask

    // Asserts reset at the current time, checks the async reset values, releases at negedge.
    task automatic do_reset();
        s_valid = 1'b0;
        m_ready = 1'b0;
        rst     = 1'b1;
        #1;
        check_eq("rst_s_ready", s_ready, 1);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_bin", m_bin, 0);
        check_eq("rst_m_re", $signed(m_re), 0);
        check_eq("rst_m_im", $signed(m_im), 0);
        check_eq("rst_m_last", m_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_frame_cnt", frame_cnt, 0);
        check_eq("rst_fft_x_zero", (fft_x == '0), 1);
`ifdef FFT8_MAG_EN
        check_eq("rst_m_mag", $signed(m_mag), 0);
`endif
        @(negedge clk);
        rst     = 1'b0;
        exp_cnt = '0;
        for (int j = 0; j < 8; j++) last_x[j] = 0;
    endtask

    // Offers n samples; fft_x must hold the previous frame throughout the fill.
    // After a full frame s_valid stays high with junk data so busy-time samples are exercised.
    task automatic send_frame(input int fr[8], input int n, input bit gaps);
        int t;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = fr[i];
            t = 0;
            while (!s_ready && t < 60) begin
                @(negedge clk);
                t++;
            end
            check_eq("fill_s_ready", s_ready, 1);
            check_eq("fill_busy", busy, 0);
            for (int j = 0; j < 8; j++)
                check_eq("fill_x_hold", $signed(fft_x[j*DW +: DW]), last_x[j]);
            @(negedge clk);
        end
        if (n == 8) begin
            exp_frame = fr;
            s_data    = $urandom;
        end
    endtask

    // mode 0: m_ready always 1, 1: toggles 1/0, 2: random. Stops after stop_at transfers.
    task automatic drain_frame(input int mode, input int stop_at);
        logic [8*DW-1:0] v;
        int er[8];
        int ei[8];
        int lat;
        int idx;
        int guard;
        bit mr;
        v = pack(exp_frame);
        for (int k = 0; k < 8; k++) begin
            er[k] = dft(v, k, 1'b0);
            ei[k] = dft(v, k, 1'b1);
        end
        lat = 1;
        while (!m_valid && lat < 40) begin
            check_eq("settle_busy", busy, 1);
            check_eq("settle_s_ready", s_ready, 0);
            @(negedge clk);
            lat++;
        end
        check_eq("bin0_latency", lat, SETTLE + 2);
        for (int j = 0; j < 8; j++) begin
            check_eq("launch_x", $signed(fft_x[j*DW +: DW]), exp_frame[j]);
            last_x[j] = exp_frame[j];
        end
        idx   = 0;
        guard = 0;
        while (idx < stop_at && guard < 100) begin
            case (mode)
                0:       mr = 1'b1;
                1:       mr = (guard % 2 == 0);
                default: mr = 1'($urandom_range(0, 1));
            endcase
            m_ready = mr;
            check_eq("drain_m_valid", m_valid, 1);
            check_eq("drain_m_bin", m_bin, idx);
            check_eq("drain_m_re", $signed(m_re), er[idx]);
            check_eq("drain_m_im", $signed(m_im), ei[idx]);
            check_eq("drain_m_last", m_last, (idx == 7));
            check_eq("drain_s_ready", s_ready, 0);
`ifdef FFT8_MAG_EN
            check_eq("drain_m_mag", $signed(m_mag),
                     (er[idx] < 0 ? -er[idx] : er[idx]) + (ei[idx] < 0 ? -ei[idx] : ei[idx]));
`endif
            @(negedge clk);
            if (mr) idx++;
            guard++;
        end
        if (guard >= 100) check_eq("drain_timeout", idx, stop_at);
        m_ready = 1'b0;
        if (stop_at == 8) begin
            s_valid = 1'b0;
            exp_cnt = exp_cnt + 16'd1;
            check_eq("end_m_valid", m_valid, 0);
            check_eq("end_s_ready", s_ready, 1);
            check_eq("end_busy", busy, 0);
            check_eq("end_frame_cnt", frame_cnt, exp_cnt);
        end
    endtask

    function automatic void rand_frame(output int f[8]);
        for (int i = 0; i < 8; i++) f[i] = int'($urandom_range(0, 2000)) - 1000;
    endfunction

    initial begin
        int f[8];
        @(negedge clk);
        do_reset();

        f = '{1, 0, 0, 0, 0, 0, 0, 0};
        send_frame(f, 8, 1'b0);
        drain_frame(0, 8);

        f = '{1, 1, 1, 1, 1, 1, 1, 1};
        send_frame(f, 8, 1'b0);
        drain_frame(0, 8);

        f = '{1, 2, 3, 4, 4, 3, 2, 1};
        send_frame(f, 8, 1'b0);
        drain_frame(0, 8);

        rand_frame(f);
        send_frame(f, 8, 1'b1);
        drain_frame(1, 8);

        // Reset mid-fill, then mid-drain, then a clean frame.
        rand_frame(f);
        send_frame(f, 5, 1'b0);
        do_reset();
        rand_frame(f);
        send_frame(f, 8, 1'b0);
        drain_frame(0, 3);
        do_reset();
        rand_frame(f);
        send_frame(f, 8, 1'b0);
        drain_frame(0, 8);

        for (int r = 0; r < 30; r++) begin
            rand_frame(f);
            send_frame(f, 8, 1'b1);
            drain_frame(2, 8);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
